// File: rtl/scan_dec_ctrl_pkg.sv
// rtl/scan_dec_ctrl_pkg.sv - shared state encoding and sizing for the scan sequencer
package scan_pkg;

  localparam int ROWS  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2,
    BLANK = 2'd3
  } scan_state_e;

  // Row after idx, wrapping 7 -> 0 through natural 3-bit overflow.
  function automatic logic [SEL_W-1:0] next_row(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/scan_dec_ctrl_if.sv
// rtl/scan_dec_ctrl_if.sv - control-register side and decoder side signals of the scan sequencer
interface scan_dec_ctrl_if
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16
);

  logic               i_en;
  logic [ROWS-1:0]    i_mask;
  logic [DWELL_W-1:0] i_dwell;
  logic               i_opt;
  logic [SEL_W-1:0]   o_sel;
  logic               o_opt;
  logic               o_valid;
  logic               o_frame;

  modport master (
    output i_en, i_mask, i_dwell, i_opt,
    input  o_sel, o_opt, o_valid, o_frame
  );

  modport slave (
    input  i_en, i_mask, i_dwell, i_opt,
    output o_sel, o_opt, o_valid, o_frame
  );

endinterface

// File: rtl/scan_rr_pick.sv
// rtl/scan_rr_pick.sv - rotating priority finder: first set mask bit at or after start, wrapping
module scan_rr_pick
  import scan_pkg::*;
(
  input  logic [ROWS-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Walk offsets from far to near so the nearest enabled row is written last and wins.
  always_comb begin
    idx = start;
    any = 1'b0;
    for (int k = ROWS - 1; k >= 0; k--) begin
      if (mask[start + SEL_W'(k)]) begin
        idx = start + SEL_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_dec_ctrl.sv
// rtl/scan_dec_ctrl.sv - round-robin row scan sequencer driving the 3-to-8 select decoder
// Optional inter-row blanking gap enabled by SCAN_BLANK_EN.
module scan_dec_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input logic             i_clk,
  input logic             i_rst,
  scan_dec_ctrl_if.slave  bus
);

  if (BLANK_CYC < 1 || BLANK_CYC > 15) begin : g_blank_range
    $error("BLANK_CYC must be in 1..15");
  end

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);
`ifdef SCAN_BLANK_EN
  localparam logic [DWELL_W-1:0] BLANK_LD = DWELL_W'(BLANK_CYC);
`endif

  scan_state_e        state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               opt_q;
  logic               valid_q;
  logic               frame_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               first_q;
  logic [SEL_W-1:0]   start_q;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DWELL_W-1:0] dwell_ld;
  logic               cnt_last;

  scan_rr_pick u_pick (
    .mask  (bus.i_mask),
    .start (start_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign dwell_ld = (bus.i_dwell == '0) ? CNT_ONE : bus.i_dwell;
  assign cnt_last = (cnt_q == CNT_ONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      opt_q   <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      start_q <= '0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.i_en && pick_any) begin
            state_q <= SEEK;
            first_q <= 1'b1;
            start_q <= '0;
          end
        end

        SEEK: begin
          if (!bus.i_en || !pick_any) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            sel_q   <= pick_idx;
            opt_q   <= bus.i_opt;
            cnt_q   <= dwell_ld;
            valid_q <= 1'b1;
            // A pick at or below the previous row means the scan wrapped around.
            frame_q <= !first_q && (pick_idx <= sel_q);
            first_q <= 1'b0;
            start_q <= next_row(pick_idx);
            state_q <= DWELL;
          end
        end

        DWELL: begin
          if (!bus.i_en) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_last) begin
              valid_q <= 1'b0;
`ifdef SCAN_BLANK_EN
              cnt_q   <= BLANK_LD;
              state_q <= BLANK;
`else
              state_q <= SEEK;
`endif
            end
          end
        end

`ifdef SCAN_BLANK_EN
        BLANK: begin
          valid_q <= 1'b0;
          if (!bus.i_en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_last) begin
              state_q <= SEEK;
            end
          end
        end
`endif

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sel   = sel_q;
  assign bus.o_opt   = opt_q;
  assign bus.o_valid = valid_q;
  assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_scan_dec_ctrl.sv
// tb/tb_scan_dec_ctrl.sv - directed self-checking bench for scan_dec_ctrl
module tb_scan_dec_ctrl;
  import scan_pkg::*;

  localparam int DW = 16;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  scan_dec_ctrl_if #(.DWELL_W(DW)) bus ();

  scan_dec_ctrl #(.DWELL_W(DW), .BLANK_CYC(BC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drop_en();
    bus.i_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_mask = '0; bus.i_dwell = '0; bus.i_opt = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd0 || bus.o_opt !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs sel=%0d opt=%b valid=%b frame=%b required 0 0 0 0",
               bus.o_sel, bus.o_opt, bus.o_valid, bus.o_frame);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_valid got %b required 0", bus.o_valid);
    end
  endtask

  task automatic test_full_scan();
    logic       ev, ef;
    logic [2:0] es;
    bus.i_mask = 8'hFF; bus.i_dwell = 16'd3; bus.i_opt = 1'b0; bus.i_en = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_seek_valid got %b required 0", bus.o_valid);
    end
    for (int r = 0; r <= 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        ev = (c < 3);
        ef = (c == 0 && r == 8);
        es = 3'(r % 8);
        total++;
        if (bus.o_valid !== ev || bus.o_frame !== ef || bus.o_sel !== es) begin
          bad++;
          $display("FAIL full_scan r=%0d c=%0d sel=%0d valid=%b frame=%b required %0d %b %b",
                   r, c, bus.o_sel, bus.o_valid, bus.o_frame, es, ev, ef);
        end
      end
    end
    drop_en();
  endtask

  task automatic test_sparse();
    logic [2:0] rows [3];
    logic       ev, ef;
    rows = '{3'd2, 3'd5, 3'd7};
    bus.i_mask = 8'b1010_0100; bus.i_dwell = 16'd0; bus.i_en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        ev = (c == 0);
        ef = (c == 0 && r >= 3 && (r % 3) == 0);
        total++;
        if (bus.o_valid !== ev || bus.o_frame !== ef || bus.o_sel !== rows[r % 3]) begin
          bad++;
          $display("FAIL sparse r=%0d c=%0d sel=%0d valid=%b frame=%b required %0d %b %b",
                   r, c, bus.o_sel, bus.o_valid, bus.o_frame, rows[r % 3], ev, ef);
        end
      end
    end
    drop_en();
  endtask

  task automatic test_single_row();
    logic ev, ef;
    bus.i_mask = 8'h10; bus.i_dwell = 16'd2; bus.i_en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        ev = (c < 2);
        ef = (c == 0 && r > 0);
        total++;
        if (bus.o_valid !== ev || bus.o_frame !== ef || bus.o_sel !== 3'd4) begin
          bad++;
          $display("FAIL single r=%0d c=%0d sel=%0d valid=%b frame=%b required 4 %b %b",
                   r, c, bus.o_sel, bus.o_valid, bus.o_frame, ev, ef);
        end
      end
    end
    drop_en();
  endtask

  task automatic test_opt_latch();
    bus.i_mask = 8'h03; bus.i_dwell = 16'd4; bus.i_opt = 1'b0; bus.i_en = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd0 || bus.o_opt !== 1'b0 || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL opt_row0 sel=%0d opt=%b valid=%b required 0 0 1", bus.o_sel, bus.o_opt, bus.o_valid);
    end
    bus.i_opt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.o_opt !== 1'b0) begin
        bad++;
        $display("FAIL opt_hold c=%0d got %b required 0", c, bus.o_opt);
      end
    end
    @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd1 || bus.o_opt !== 1'b1 || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL opt_row1 sel=%0d opt=%b valid=%b required 1 1 1", bus.o_sel, bus.o_opt, bus.o_valid);
    end
    bus.i_opt = 1'b0;
    drop_en();
  endtask

  task automatic test_abort();
    bus.i_mask = 8'h40; bus.i_dwell = 16'd5; bus.i_opt = 1'b1; bus.i_en = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd6 || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre sel=%0d valid=%b required 6 1", bus.o_sel, bus.o_valid);
    end
    bus.i_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_sel !== 3'd6 || bus.o_opt !== 1'b1) begin
        bad++;
        $display("FAIL abort_hold c=%0d sel=%0d opt=%b valid=%b required 6 1 0",
                 c, bus.o_sel, bus.o_opt, bus.o_valid);
      end
    end
    bus.i_mask = 8'hFF; bus.i_opt = 1'b0; bus.i_en = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart_latency valid=%b required 0", bus.o_valid);
    end
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b1 || bus.o_sel !== 3'd0 || bus.o_frame !== 1'b0 || bus.o_opt !== 1'b0) begin
      bad++;
      $display("FAIL restart_first sel=%0d valid=%b frame=%b opt=%b required 0 1 0 0",
               bus.o_sel, bus.o_valid, bus.o_frame, bus.o_opt);
    end
    drop_en();
  endtask

  task automatic test_mask_zero();
    logic ev;
    bus.i_mask = 8'hFF; bus.i_dwell = 16'd2; bus.i_en = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd0 || bus.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL mask0_pre sel=%0d valid=%b required 0 1", bus.o_sel, bus.o_valid);
    end
    bus.i_mask = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ev = (c == 0);
      total++;
      if (bus.o_valid !== ev || bus.o_frame !== 1'b0) begin
        bad++;
        $display("FAIL mask0_tail c=%0d valid=%b frame=%b required %b 0", c, bus.o_valid, bus.o_frame, ev);
      end
    end
    bus.i_mask = 8'h08;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd3 || bus.o_valid !== 1'b1 || bus.o_frame !== 1'b0) begin
      bad++;
      $display("FAIL mask0_restart sel=%0d valid=%b frame=%b required 3 1 0",
               bus.o_sel, bus.o_valid, bus.o_frame);
    end
    drop_en();
  endtask

  task automatic test_reset_mid();
    bus.i_mask = 8'h20; bus.i_dwell = 16'd10; bus.i_opt = 1'b1; bus.i_en = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd5 || bus.o_valid !== 1'b1 || bus.o_opt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre sel=%0d valid=%b opt=%b required 5 1 1", bus.o_sel, bus.o_valid, bus.o_opt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.o_sel !== 3'd0 || bus.o_valid !== 1'b0 || bus.o_frame !== 1'b0 || bus.o_opt !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async sel=%0d valid=%b frame=%b opt=%b required 0 0 0 0",
               bus.o_sel, bus.o_valid, bus.o_frame, bus.o_opt);
    end
    @(negedge clk);
    rst = 1'b0; bus.i_en = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle valid=%b required 0", bus.o_valid);
    end
    bus.i_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.o_sel !== 3'd5 || bus.o_valid !== 1'b1 || bus.o_frame !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_restart sel=%0d valid=%b frame=%b required 5 1 0",
               bus.o_sel, bus.o_valid, bus.o_frame);
    end
    drop_en();
  endtask

`ifdef SCAN_BLANK_EN
  task automatic test_blank();
    logic ev;
    bus.i_mask = 8'hFF; bus.i_dwell = 16'd4; bus.i_en = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4 + BC + 1; c++) begin
        @(negedge clk);
        ev = (c < 4);
        total++;
        if (bus.o_valid !== ev || bus.o_sel !== 3'(r)) begin
          bad++;
          $display("FAIL blank r=%0d c=%0d sel=%0d valid=%b required %0d %b",
                   r, c, bus.o_sel, bus.o_valid, r, ev);
        end
      end
    end
    drop_en();
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_sparse();
    test_single_row();
    test_opt_latch();
    test_abort();
    test_mask_zero();
    test_reset_mid();
`ifdef SCAN_BLANK_EN
    test_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
